// File: rtl/branch_target_predictor.sv
// branch_target_predictor
//   Fetch-side branch predictor: a direct-mapped BTB of 2-bit saturating
//   counters. It looks up fetch_pc combinationally and is trained by
//   resolution updates from the downstream branch resolver.
//   Optional build macro BP_STATS_EN adds branch / mispredict statistics
//   counters (stat_branches, stat_mispredicts).
module branch_target_predictor #(
    parameter int unsigned ENTRIES = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] fetch_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        bp_clear,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    output logic        upd_mispredict
`ifdef BP_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);

    // Derived geometry; not meant to be overridden.
    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 30 - IDX_W;

    // Table state. valid/ctr need reset, tag/target do not.
    logic [ENTRIES-1:0]      valid_q;
    logic [ENTRIES-1:0][1:0] ctr_q;
    logic [TAG_W-1:0]        tag_q    [ENTRIES];
    logic [31:0]             target_q [ENTRIES];
    logic                    mispredict_q;

    // Lookup side
    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;

    // Update side
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;
    logic [1:0]       ctr_d;
    logic             ctr_we;
    logic             target_we;
    logic             alloc;
    logic             mispredict_d;

    // Byte-offset bits of the update PC carry no information for the table.
    logic             unused_upd_pc_lsbs;
    assign unused_upd_pc_lsbs = ^upd_pc[1:0];

    assign f_idx = fetch_pc[IDX_W+1:2];
    assign f_tag = fetch_pc[31:IDX_W+2];
    assign u_idx = upd_pc[IDX_W+1:2];
    assign u_tag = upd_pc[31:IDX_W+2];

    // Combinational prediction from the registered table (no write bypass).
    always_comb begin
        f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        pred_taken  = f_hit && ctr_q[f_idx][1];
        pred_target = pred_taken ? target_q[f_idx] : (fetch_pc + 32'd4);
    end

    // Next-state for the single entry addressed by the resolution update.
    always_comb begin
        u_hit        = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        ctr_d        = ctr_q[u_idx];
        ctr_we       = 1'b0;
        target_we    = 1'b0;
        alloc        = 1'b0;
        mispredict_d = upd_valid && (upd_taken != upd_pred_taken);
        if (upd_valid && !bp_clear) begin
            if (u_hit) begin
                ctr_we = 1'b1;
                if (upd_taken) begin
                    ctr_d     = (ctr_q[u_idx] == 2'b11) ? 2'b11 : ctr_q[u_idx] + 2'd1;
                    target_we = 1'b1;
                end else begin
                    ctr_d = (ctr_q[u_idx] == 2'b00) ? 2'b00 : ctr_q[u_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                // Taken miss allocates, evicting whatever shares the index.
                ctr_we    = 1'b1;
                target_we = 1'b1;
                alloc     = 1'b1;
                ctr_d     = 2'b10;
            end
        end
    end

    // Control state: valid bits, counters and the mispredict pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q      <= '0;
            ctr_q        <= {ENTRIES{2'b01}};
            mispredict_q <= 1'b0;
        end else begin
            mispredict_q <= mispredict_d;
            if (bp_clear) begin
                valid_q <= '0;
            end else begin
                if (alloc) begin
                    valid_q[u_idx] <= 1'b1;
                end
                if (ctr_we) begin
                    ctr_q[u_idx] <= ctr_d;
                end
            end
        end
    end

    // Payload arrays: tags and targets, written only when training allows it.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (alloc) begin
                tag_q[u_idx] <= u_tag;
            end
            if (target_we) begin
                target_q[u_idx] <= upd_target;
            end
        end
    end

    assign upd_mispredict = mispredict_q;

`ifdef BP_STATS_EN
    logic [31:0] stat_branches_q;
    logic [31:0] stat_mispredicts_q;

    // Statistics: cleared only by reset, wrap naturally at 2^32.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            if (upd_valid) begin
                stat_branches_q <= stat_branches_q + 32'd1;
            end
            if (mispredict_d) begin
                stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
            end
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule
